// File: rtl/vga_pkg.sv
// Shared timing constants and pixel types for the pixel fetch pipeline.
// Palette reset ramp helper lives here so the regfile and any model agree on it.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int SCALE_SH = 2;
    localparam int IDX_W    = 4;
    localparam int ADDR_W   = 15;
    localparam int PAL_N    = 1 << IDX_W;
    localparam int CELLS_X  = H_ACTIVE >> SCALE_SH;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    typedef logic [IDX_W-1:0] pal_idx_t;

    // Entry i resets to a grey ramp: every channel equals 8'h11*i.
    function automatic rgb_t pal_reset_val(input int i);
        logic [7:0] v;
        v = 8'(17 * i);
        return '{b: v, g: v, r: v};
    endfunction

endpackage

// File: rtl/pixel_fetch_pipe_if.sv
// Framebuffer read bus between the pixel fetch pipeline (master) and the RAM (slave).
interface pixel_fetch_pipe_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    pal_idx_t          mem_data_i;

    modport master (output mem_addr_o, output mem_rd_o, input  mem_data_i);
    modport slave  (input  mem_addr_o, input  mem_rd_o, output mem_data_i);

endinterface

// File: rtl/palette_regfile.sv
// 16 x 24-bit palette: one synchronous write port, one asynchronous read port.
// A read of an entry written in the same cycle returns the old contents.
module palette_regfile
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we_i,
    input  pal_idx_t wr_idx_i,
    input  rgb_t     wr_data_i,
    input  pal_idx_t rd_idx_i,
    output rgb_t     rd_data_o
);

    rgb_t pal_q [PAL_N];
    rgb_t pal_d [PAL_N];

    // NOTE: start every always_comb from a full default so no path leaves a bit unassigned (no latch).
    always_comb begin
        pal_d = pal_q;
        if (we_i) pal_d[wr_idx_i] = wr_data_i;
    end

    // NOTE: this array is small flop storage with a defined reset ramp, so resetting it is intended; a RAM would not be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_reset_val(i);
        end else begin
            pal_q <= pal_d;
        end
    end

    assign rd_data_o = pal_q[rd_idx_i];

endmodule

// File: rtl/pixel_fetch_pipe.sv
// Prefetches framebuffer palette indices LAT=MEM_LAT+2 pixels ahead of the scan and returns colour aligned to x_pos_i.
// Optional cursor-cell inversion is enabled by defining CURSOR_OVERLAY_EN.
module pixel_fetch_pipe
    import vga_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x_pos_i,
    input  logic [31:0] y_pos_i,
    pixel_fetch_pipe_if.master mem,
    input  logic        pal_we_i,
    input  pal_idx_t    pal_idx_i,
    input  rgb_t        pal_data_i,
`ifdef CURSOR_OVERLAY_EN
    input  logic [7:0]  cursor_x_i,
    input  logic [7:0]  cursor_y_i,
`endif
    output rgb_t        rgb_o,
    output logic        de_o,
    output logic        frame_start_o
);

    localparam int LAT = MEM_LAT + 2;

    logic [31:0]       x_ahead;
    logic [31:0]       xf;
    logic [31:0]       yf;
    logic              in_scan;
    logic              inrange;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              mem_rd_d, mem_rd_q;
    logic [MEM_LAT-1:0] vld_d, vld_q;
    rgb_t              rgb_d, rgb_q;
    rgb_t              pal_rd;
    logic              de_d, de_q;
    logic              fs_d, fs_q;
    logic [7:0]        frame_cnt_d, frame_cnt_q;
`ifdef CURSOR_OVERLAY_EN
    logic              tag_a_d, tag_a_q;
    logic [MEM_LAT-1:0] tag_d, tag_q;
`endif

    // Stage A: lookahead position, wrapping into the next line or frame.
    always_comb begin
        in_scan = (x_pos_i < 32'(H_TOTAL)) && (y_pos_i < 32'(V_TOTAL));
        x_ahead = x_pos_i + 32'(LAT);
        xf      = x_ahead;
        yf      = y_pos_i;
        if (x_ahead >= 32'(H_TOTAL)) begin
            xf = x_ahead - 32'(H_TOTAL);
            yf = (y_pos_i == 32'(V_TOTAL - 1)) ? 32'd0 : y_pos_i + 32'd1;
        end
        inrange    = in_scan && (xf < 32'(H_ACTIVE)) && (yf < 32'(V_ACTIVE));
        mem_rd_d   = inrange;
        mem_addr_d = '0;
        if (inrange) begin
            mem_addr_d = ADDR_W'(yf >> SCALE_SH) * ADDR_W'(CELLS_X) + ADDR_W'(xf >> SCALE_SH);
        end
`ifdef CURSOR_OVERLAY_EN
        tag_a_d = inrange && ((xf >> SCALE_SH) == 32'(cursor_x_i))
                          && ((yf >> SCALE_SH) == 32'(cursor_y_i));
`endif
    end

    // The valid flag (and cursor tag) ride alongside the read for MEM_LAT cycles.
    always_comb begin
        vld_d[0] = mem_rd_q;
        for (int i = 1; i < MEM_LAT; i++) vld_d[i] = vld_q[i-1];
`ifdef CURSOR_OVERLAY_EN
        tag_d[0] = tag_a_q;
        for (int i = 1; i < MEM_LAT; i++) tag_d[i] = tag_q[i-1];
`endif
    end

    palette_regfile u_palette (
        .clk       (clk),
        .rst       (rst),
        .we_i      (pal_we_i),
        .wr_idx_i  (pal_idx_i),
        .wr_data_i (pal_data_i),
        .rd_idx_i  (mem.mem_data_i),
        .rd_data_o (pal_rd)
    );

    // Stage P: resolve the returned index, blank when the fetch was outside the visible area.
    always_comb begin
        de_d  = vld_q[MEM_LAT-1];
        rgb_d = '0;
        if (vld_q[MEM_LAT-1]) rgb_d = pal_rd;
`ifdef CURSOR_OVERLAY_EN
        if (vld_q[MEM_LAT-1] && tag_q[MEM_LAT-1] && frame_cnt_q[4]) rgb_d = rgb_t'(~pal_rd);
`endif
        fs_d        = (x_pos_i == 32'(H_TOTAL - 1)) && (y_pos_i == 32'(V_TOTAL - 1));
        frame_cnt_d = fs_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            vld_q       <= '0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
`ifdef CURSOR_OVERLAY_EN
            tag_a_q     <= 1'b0;
            tag_q       <= '0;
`endif
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            vld_q       <= vld_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CURSOR_OVERLAY_EN
            tag_a_q     <= tag_a_d;
            tag_q       <= tag_d;
`endif
        end
    end

    assign mem.mem_addr_o = mem_addr_q;
    assign mem.mem_rd_o   = mem_rd_q;
    assign rgb_o          = rgb_q;
    assign de_o           = de_q;
    assign frame_start_o  = fs_q;

endmodule

// File: tb/tb_pixel_fetch_pipe.sv
// Directed bench for pixel_fetch_pipe; the RAM model returns addr[3:0] after MEM_LAT cycles.
// Define CURSOR_OVERLAY_EN for both bench and RTL to include the cursor steps.
module tb_pixel_fetch_pipe;

    localparam int MEM_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_pos, y_pos;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_data;
    logic [23:0] rgb;
    logic        de, frame_start;
    logic [3:0]  ram_pipe [MEM_LAT];
`ifdef CURSOR_OVERLAY_EN
    logic [7:0]  cursor_x = 8'd1;
    logic [7:0]  cursor_y = 8'd0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_fetch_pipe_if mem_if ();

    pixel_fetch_pipe #(.MEM_LAT(MEM_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .x_pos_i       (x_pos),
        .y_pos_i       (y_pos),
        .mem           (mem_if),
        .pal_we_i      (pal_we),
        .pal_idx_i     (pal_idx),
        .pal_data_i    (pal_data),
`ifdef CURSOR_OVERLAY_EN
        .cursor_x_i    (cursor_x),
        .cursor_y_i    (cursor_y),
`endif
        .rgb_o         (rgb),
        .de_o          (de),
        .frame_start_o (frame_start)
    );

    // Framebuffer model: cell content is the low nibble of its address.
    always @(posedge clk) begin
        ram_pipe[0] <= mem_if.mem_addr_o[3:0];
        for (int i = 1; i < MEM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_if.mem_data_i = ram_pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next clock window and present a scan position for it.
    task automatic cyc(input int x, input int y);
        @(posedge clk);
        #1;
        x_pos = 32'(x);
        y_pos = 32'(y);
    endtask

    initial begin
        rst = 1'b1; x_pos = '0; y_pos = '0;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;

        // Reset state
        repeat (3) cyc(0, 0);
        check("rst_rgb",   32'(rgb), 32'h0);
        check("rst_de",    32'(de), 32'h0);
        check("rst_rd",    32'(mem_if.mem_rd_o), 32'h0);
        check("rst_addr",  32'(mem_if.mem_addr_o), 32'h0);
        check("rst_fs",    32'(frame_start), 32'h0);
        check("rst_fcnt",  32'(dut.frame_cnt_q), 32'h0);

        // Line y=0 from a cold pipeline
        rst = 1'b0;
        for (int x = 0; x < 800; x++) begin
            if (x != 0) cyc(x, 0);
            if (x == 2) check("cold_de_x2", 32'(de), 32'h0);
            if (x == 3) begin
                check("first_de_x3",  32'(de), 32'h1);
                check("first_rgb_x3", 32'(rgb), 32'h000000);
            end
            if (x == 5) begin
                check("y0_x5_rgb", 32'(rgb), 32'h111111);
                check("y0_x5_de",  32'(de), 32'h1);
            end
            if (x >= 640) begin
                check("hblank_rgb", 32'(rgb), 32'h0);
                check("hblank_de",  32'(de), 32'h0);
            end
        end

        // Line wrap y=3 -> y=4
        for (int x = 790; x < 800; x++) begin
            cyc(x, 3);
            if (x == 796) begin
                check("pre_wrap_rd",   32'(mem_if.mem_rd_o), 32'h0);
                check("pre_wrap_addr", 32'(mem_if.mem_addr_o), 32'h0);
            end
            if (x == 798) begin
                check("wrap_addr", 32'(mem_if.mem_addr_o), 32'd160);
                check("wrap_rd",   32'(mem_if.mem_rd_o), 32'h1);
            end
        end
        for (int x = 0; x < 6; x++) begin
            cyc(x, 4);
            if (x == 0) begin
                check("y4_x0_de",  32'(de), 32'h1);
                check("y4_x0_rgb", 32'(rgb), 32'h000000);
            end
            if (x == 4) check("y4_x4_rgb", 32'(rgb), 32'h111111);
        end

        // Frame wrap
        for (int x = 795; x < 800; x++) cyc(x, 524);
        check("fs_before",   32'(frame_start), 32'h0);
        check("fcnt_before", 32'(dut.frame_cnt_q), 32'h0);
        cyc(0, 0);
        check("fs_pulse",     32'(frame_start), 32'h1);
        check("fcnt_after",   32'(dut.frame_cnt_q), 32'h1);
        check("fwrap_addr",   32'(mem_if.mem_addr_o), 32'h0);
        check("fwrap_rd",     32'(mem_if.mem_rd_o), 32'h1);
        cyc(1, 0);
        check("fs_once",      32'(frame_start), 32'h0);

        // Positions outside the raster
        for (int i = 0; i < 4; i++) begin
            cyc(2000, 2000);
            if (i == 1) check("oor_rd", 32'(mem_if.mem_rd_o), 32'h0);
            if (i == 3) begin
                check("oor_de",  32'(de), 32'h0);
                check("oor_rgb", 32'(rgb), 32'h0);
            end
        end
        cyc(10, 600);
        cyc(11, 600);
        check("oor_y_rd",   32'(mem_if.mem_rd_o), 32'h0);
        check("oor_y_addr", 32'(mem_if.mem_addr_o), 32'h0);

        // Palette write colliding with a lookup of the same entry
        for (int x = 0; x <= 12; x++) begin
            cyc(x, 0);
            pal_we   = (x == 7);
            pal_idx  = 4'd2;
            pal_data = 24'hFF0000;
            if (x == 8)  check("pal_old",   32'(rgb), 32'h222222);
            if (x == 9)  check("pal_new",   32'(rgb), 32'hFF0000);
            if (x == 12) check("pal_other", 32'(rgb), 32'h333333);
        end
        pal_we = 1'b0;

        // Mid-line reset
        for (int x = 90; x <= 140; x++) begin
            cyc(x, 0);
            rst = (x == 100);
            if (x == 100) check("mid_pre_rgb", 32'(rgb), 32'h999999);
            if (x == 101) begin
                check("mid_rst_rgb",  32'(rgb), 32'h0);
                check("mid_rst_de",   32'(de), 32'h0);
                check("mid_rst_fcnt", 32'(dut.frame_cnt_q), 32'h0);
            end
            if (x == 103) check("mid_flush_de", 32'(de), 32'h0);
            if (x == 104) begin
                check("mid_resume_de",  32'(de), 32'h1);
                check("mid_resume_rgb", 32'(rgb), 32'hAAAAAA);
            end
            if (x == 136) check("pal_reset_restore", 32'(rgb), 32'h222222);
        end
        rst = 1'b0;

`ifdef CURSOR_OVERLAY_EN
        // Cursor at cell (1,0): blink phase on once frame_cnt reaches 16
        repeat (16) cyc(799, 524);
        for (int x = 0; x <= 8; x++) begin
            cyc(x, 1);
            if (x == 4) check("cur_fcnt", 32'(dut.frame_cnt_q), 32'd16);
            if (x >= 4 && x <= 7) check("cur_inv", 32'(rgb), 32'hEEEEEE);
            if (x == 8) check("cur_neighbour", 32'(rgb), 32'h222222);
        end
        repeat (240) cyc(799, 524);
        for (int x = 0; x <= 5; x++) begin
            cyc(x, 2);
            if (x == 5) check("cur_off", 32'(rgb), 32'h111111);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
